// File: rtl/bcd_stopwatch_core.sv
// bcd_stopwatch_core
//   BCD stopwatch with start/stop/clear control, optional lap capture and a
//   multiplexed active-low 7-segment display driver.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   -> lap capture register, lap hold timer and lap_active output
//   undefined -> lap input ignored, lap_active tied low, live value displayed
//
// Ports
//   CLK        in   sole clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   start      in   level; rising edge starts / resumes counting
//   stop       in   level; rising edge pauses counting
//   clear      in   level; high zeroes the count and returns to IDLE
//   lap        in   level; rising edge captures the lap value (RUN/PAUSE)
//   value      out  live BCD count, digit 0 in bits [3:0]
//   running    out  high while in RUN
//   lap_active out  high while the captured lap value is displayed
//   wrap       out  one-cycle pulse when the count rolls over from all 9s
//   seg        out  segments g..a, active-low, for the scanned digit
//   digit_sel  out  one-hot active-low digit enable
//
// Control handshake: start/stop/lap are plain levels; an event is the first
// cycle a level is seen high after being low. clear is level-sensitive.
module bcd_stopwatch_core #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 120000,
   parameter int SCAN_DIV = 1024,
   parameter int LAP_HOLD = 20
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                start,
   input  logic                stop,
   input  logic                clear,
   input  logic                lap,
   output logic [4*DIGITS-1:0] value,
   output logic                running,
   output logic                lap_active,
   output logic                wrap,
   output logic [6:0]          seg,
   output logic [DIGITS-1:0]   digit_sel
);

   localparam int VW = 4 * DIGITS;
   localparam int TW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              start_prev_q, start_prev_d;
   logic              stop_prev_q, stop_prev_d;
   logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
   logic [VW-1:0]     value_q, value_d;
   logic              running_q, running_d;
   logic              wrap_q, wrap_d;
   logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
   logic              scan_on_q, scan_on_d;
   logic [IW-1:0]     scan_idx_q, scan_idx_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] digit_sel_q, digit_sel_d;

   logic              tick, start_edge, stop_edge, scan_step;
   logic              carry, all_nines;
   logic [VW-1:0]     inc_value;
   logic [VW-1:0]     disp_d;
   logic [3:0]        cur_digit;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   // Tick divider, BCD counter and run-control FSM.
   always_comb begin
      start_prev_d = start;
      stop_prev_d  = stop;
      start_edge   = start & ~start_prev_q;
      stop_edge    = stop & ~stop_prev_q;

      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

      // Ripple BCD increment; the all-9s case naturally yields zero.
      inc_value = value_q;
      carry     = 1'b1;
      all_nines = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (value_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
         if (carry) begin
            if (value_q[4*i +: 4] >= 4'd9) begin
               inc_value[4*i +: 4] = 4'd0;
            end else begin
               inc_value[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end

      state_d = state_q;
      value_d = value_q;
      wrap_d  = 1'b0;
      if ((state_q == ST_RUN) && tick) begin
         value_d = inc_value;
         wrap_d  = all_nines;
      end

      // Same-cycle priority: clear, then stop, then start.
      if (clear) begin
         state_d    = ST_IDLE;
         value_d    = '0;
         tick_cnt_d = '0;
         wrap_d     = 1'b0;
      end else if (stop_edge) begin
         if (state_q == ST_RUN) state_d = ST_PAUSE;
      end else if (start_edge) begin
         if (state_q != ST_RUN) state_d = ST_RUN;
      end

      running_d = (state_d == ST_RUN);
   end

`ifdef STOPWATCH_LAP_EN
   localparam int LW = $clog2(LAP_HOLD + 1);
   localparam logic [LW-1:0] LAP_LOAD = LW'(LAP_HOLD);

   logic          lap_prev_q, lap_prev_d;
   logic          lap_edge, lap_take;
   logic [LW-1:0] lap_timer_q, lap_timer_d;
   logic [VW-1:0] lap_value_q, lap_value_d;
   logic          lap_active_q, lap_active_d;

   always_comb begin
      lap_prev_d = lap;
      lap_edge   = lap & ~lap_prev_q;
      // Lap is the lowest-priority event and is meaningless in IDLE.
      lap_take   = lap_edge & ~clear & ~stop_edge & ~start_edge & (state_q != ST_IDLE);

      lap_timer_d = lap_timer_q;
      lap_value_d = lap_value_q;
      if (tick && (lap_timer_q != '0)) lap_timer_d = lap_timer_q - LW'(1);
      if (lap_take) begin
         lap_value_d = value_q;
         lap_timer_d = LAP_LOAD;
      end
      if (clear) lap_timer_d = '0;

      lap_active_d = (lap_timer_d != '0);
      disp_d       = lap_active_d ? lap_value_d : value_d;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lap_prev_q   <= 1'b1;
         lap_timer_q  <= '0;
         lap_value_q  <= '0;
         lap_active_q <= 1'b0;
      end else begin
         lap_prev_q   <= lap_prev_d;
         lap_timer_q  <= lap_timer_d;
         lap_value_q  <= lap_value_d;
         lap_active_q <= lap_active_d;
      end
   end

   assign lap_active = lap_active_q;
`else
   logic unused_lap;
   assign unused_lap = lap;
   assign disp_d     = value_d;
   assign lap_active = 1'b0;
`endif

   // Display scan. Outputs are computed from next-state data so seg always
   // matches the digit of the value visible on the same cycle.
   always_comb begin
      scan_step  = (scan_cnt_q == SCAN_LAST);
      scan_cnt_d = scan_step ? '0 : scan_cnt_q + SW'(1);
      // The first step only enables slot 0; later steps advance the index.
      scan_on_d  = scan_on_q | scan_step;
      scan_idx_d = scan_idx_q;
      if (scan_step && scan_on_q) begin
         scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
      end

      cur_digit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (scan_idx_d == IW'(i)) cur_digit = disp_d[4*i +: 4];
      end

      seg_d       = 7'h7F;
      digit_sel_d = '1;
      if (scan_on_d) begin
         seg_d       = seg7(cur_digit);
         digit_sel_d = ~(DIGITS'(1) << scan_idx_d);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_IDLE;
         start_prev_q <= 1'b1;
         stop_prev_q  <= 1'b1;
         tick_cnt_q   <= '0;
         value_q      <= '0;
         running_q    <= 1'b0;
         wrap_q       <= 1'b0;
         scan_cnt_q   <= '0;
         scan_on_q    <= 1'b0;
         scan_idx_q   <= '0;
         seg_q        <= 7'h7F;
         digit_sel_q  <= '1;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_prev_d;
         stop_prev_q  <= stop_prev_d;
         tick_cnt_q   <= tick_cnt_d;
         value_q      <= value_d;
         running_q    <= running_d;
         wrap_q       <= wrap_d;
         scan_cnt_q   <= scan_cnt_d;
         scan_on_q    <= scan_on_d;
         scan_idx_q   <= scan_idx_d;
         seg_q        <= seg_d;
         digit_sel_q  <= digit_sel_d;
      end
   end

   assign value     = value_q;
   assign running   = running_q;
   assign wrap      = wrap_q;
   assign seg       = seg_q;
   assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Bench for bcd_stopwatch_core with DIGITS=2, TICK_DIV=4, SCAN_DIV=2,
// LAP_HOLD=3. Inputs change on the falling edge; outputs are sampled on the
// falling edge. Tick phase is known because ticks fall every 4th rising edge
// after reset release or after a cycle with clear high.
module tb_bcd_stopwatch_core;

   localparam int DIGITS   = 2;
   localparam int TICK_DIV = 4;
   localparam int SCAN_DIV = 2;
   localparam int LAP_HOLD = 3;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic       CLK;
   logic       RST_N;
   logic       start, stop, clear, lap;
   logic [7:0] value;
   logic       running, lap_active, wrap;
   logic [6:0] seg;
   logic [1:0] digit_sel;

   int n_checks = 0;
   int n_fail   = 0;
   int unsigned pe_cnt;
   logic [7:0] exp_q[$];

   typedef struct {
      logic       start;
      logic       stop;
      logic       clear;
      logic       lap;
      int         cycles;
      logic [7:0] exp_value;
      logic       exp_running;
      logic       exp_wrap;
      logic       exp_lap;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs[NV];

   bcd_stopwatch_core #(
      .DIGITS  (DIGITS),
      .TICK_DIV(TICK_DIV),
      .SCAN_DIV(SCAN_DIV),
      .LAP_HOLD(LAP_HOLD)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .start     (start),
      .stop      (stop),
      .clear     (clear),
      .lap       (lap),
      .value     (value),
      .running   (running),
      .lap_active(lap_active),
      .wrap      (wrap),
      .seg       (seg),
      .digit_sel (digit_sel)
   );

   // Clock and reset-relative edge counter (drives the scan model).
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) pe_cnt <= 0;
      else        pe_cnt <= pe_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic vec_t mk(input logic s, input logic p, input logic c, input logic l,
                               input int cy, input logic [7:0] v, input logic r,
                               input logic w, input logic la);
      vec_t t;
      t.start = s; t.stop = p; t.clear = c; t.lap = l; t.cycles = cy;
      t.exp_value = v; t.exp_running = r; t.exp_wrap = w; t.exp_lap = la;
      return t;
   endfunction

   initial begin
      // Cycle numbers in comments count rising edges after the clear in v0 / v13.
      //               st sp cl lp  cyc  value  run wrap lap
      vecs[0]  = mk(0, 0, 1, 0,   1, 8'h00, 0, 0, 0);       // clear aligns tick phase
      vecs[1]  = mk(1, 0, 0, 0,   1, 8'h00, 1, 0, 0);       // start edge -> RUN
      vecs[2]  = mk(0, 0, 0, 0,   2, 8'h00, 1, 0, 0);
      vecs[3]  = mk(0, 0, 0, 0, 157, 8'h40, 1, 0, 0);       // 40 ticks
      vecs[4]  = mk(0, 1, 0, 0,   1, 8'h40, 0, 0, 0);       // stop -> PAUSE
      vecs[5]  = mk(0, 0, 0, 0,  40, 8'h40, 0, 0, 0);       // frozen for 10 ticks
      vecs[6]  = mk(1, 0, 0, 0,   1, 8'h40, 1, 0, 0);       // resume
      vecs[7]  = mk(0, 0, 0, 0,  10, 8'h43, 1, 0, 0);
      vecs[8]  = mk(0, 0, 0, 0, 220, 8'h98, 1, 0, 0);
      vecs[9]  = mk(0, 0, 0, 0,   4, 8'h99, 1, 0, 0);
      vecs[10] = mk(0, 0, 0, 0,   4, 8'h00, 1, 1, 0);       // rollover pulse
      vecs[11] = mk(0, 0, 0, 0,   1, 8'h00, 1, 0, 0);       // pulse is one cycle
      vecs[12] = mk(0, 0, 0, 0,   8, 8'h02, 1, 0, 0);
      vecs[13] = mk(1, 1, 1, 0,   1, 8'h00, 0, 0, 0);       // clear beats stop/start
      vecs[14] = mk(0, 0, 0, 1,   3, 8'h00, 0, 0, 0);       // lap in IDLE ignored
      vecs[15] = mk(1, 0, 0, 0,   1, 8'h00, 1, 0, 0);
      vecs[16] = mk(0, 0, 0, 0,   1, 8'h00, 1, 0, 0);
      vecs[17] = mk(1, 1, 0, 0,   1, 8'h00, 0, 0, 0);       // stop beats start in RUN
      vecs[18] = mk(0, 0, 0, 0,   1, 8'h00, 0, 0, 0);
      vecs[19] = mk(1, 1, 0, 0,   1, 8'h00, 0, 0, 0);       // stop beats start in PAUSE
      vecs[20] = mk(0, 0, 0, 0,   1, 8'h00, 0, 0, 0);
      vecs[21] = mk(1, 0, 0, 0,   1, 8'h00, 1, 0, 0);
      vecs[22] = mk(0, 0, 0, 1,   1, 8'h00, 1, 0, LAP_EN);  // lap edge in RUN
      vecs[23] = mk(0, 0, 0, 0,   8, 8'h02, 1, 0, LAP_EN);  // 2 of 3 hold ticks used
      vecs[24] = mk(0, 0, 0, 0,  37, 8'h12, 1, 0, 0);       // hold expired

      RST_N = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
      step(3);
      check("rst value", value, 8'h00);
      check("rst running", running, 1'b0);
      check("rst wrap", wrap, 1'b0);
      check("rst lap_active", lap_active, 1'b0);
      check("rst seg", seg, 7'h7F);
      check("rst digit_sel", digit_sel, 2'b11);

      // First scan slot appears SCAN_DIV clocks after release.
      RST_N = 1'b1;
      step(1);
      check("scan pre sel", digit_sel, 2'b11);
      check("scan pre seg", seg, 7'h7F);
      step(1);
      check("scan slot0 sel", digit_sel, 2'b10);
      check("scan slot0 seg", seg, 7'h40);

      // Count to 37 and reset asynchronously mid-count.
      start = 1'b1;
      step(1);
      check("run1 running", running, 1'b1);
      start = 1'b0;
      step(145);
      check("run1 value", value, 8'h37);
      #2 RST_N = 1'b0; start = 1'b1;
      #1;
      check("async rst value", value, 8'h00);
      check("async rst seg", seg, 7'h7F);
      check("async rst digit_sel", digit_sel, 2'b11);
      check("async rst running", running, 1'b0);
      check("async rst wrap", wrap, 1'b0);
      check("async rst lap_active", lap_active, 1'b0);

      // Release with start already high: no edge.
      step(2);
      RST_N = 1'b1;
      step(1);
      check("rel2 pre sel", digit_sel, 2'b11);
      step(1);
      check("rel2 slot0 sel", digit_sel, 2'b10);
      check("rel2 slot0 seg", seg, 7'h40);
      step(1);
      check("held start no edge", running, 1'b0);
      start = 1'b0;

      for (int i = 0; i < NV; i++) begin
         start = vecs[i].start;
         stop  = vecs[i].stop;
         clear = vecs[i].clear;
         lap   = vecs[i].lap;
         step(vecs[i].cycles);
         check($sformatf("v%0d value", i), value, vecs[i].exp_value);
         check($sformatf("v%0d running", i), running, vecs[i].exp_running);
         check($sformatf("v%0d wrap", i), wrap, vecs[i].exp_wrap);
         check($sformatf("v%0d lap_active", i), lap_active, vecs[i].exp_lap);
      end
      start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;

      // Lap capture at 0x12 (edge 57); ticks fall on edges 60, 64, 68.
      lap = 1'b1;
      step(1);
      check("lap edge lap_active", lap_active, LAP_EN);
      check("lap edge value", value, 8'h12);
      lap = 1'b0;
      for (int j = 1; j <= 14; j++) begin
         exp_q.push_back(8'h12 + 8'((57 + j) / 4 - 14));
      end
      for (int j = 1; j <= 14; j++) begin
         int p;
         int idx;
         logic [7:0] live;
         logic [7:0] disp;
         logic       la;
         logic [1:0] esel;
         logic [3:0] dig;
         step(1);
         p    = 57 + j;
         live = exp_q.pop_front();
         la   = LAP_EN && (p < 68);
         disp = la ? 8'h12 : live;
         idx  = ((int'(pe_cnt) / SCAN_DIV) - 1) % DIGITS;
         esel = ~(2'b01 << idx);
         dig  = (idx == 0) ? disp[3:0] : disp[7:4];
         check($sformatf("lap%0d value", j), value, live);
         check($sformatf("lap%0d lap_active", j), lap_active, la);
         check($sformatf("lap%0d digit_sel", j), digit_sel, esel);
         check($sformatf("lap%0d seg", j), seg, seg_of(dig));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
